// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the multicycle CPU memory access sequencer:
// FSM state encodings, IorD select values and default widths.
package mem_ctrl_pkg;

  localparam int DEF_ADDRESS_WIDTH = 32;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_WAIT_STATES   = 1;
  localparam int MAX_WAIT_STATES   = 15;
  localparam int WAIT_CNT_W        = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic IORD_INSTR = 1'b0;
  localparam logic IORD_DATA  = 1'b1;

  // Word accesses require the two low address bits to be clear.
  function automatic logic addrMisaligned(input logic [1:0] lowBits);
    return lowBits != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter used to time memory wait states; zero flag
// tells the sequencer the final wait cycle has arrived.
module mem_wait_counter
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH = WAIT_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer between the control unit and the unified memory.
// Optional alignment fault detection is enabled by MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int WAIT_STATES   = DEF_WAIT_STATES
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqIorD,
  input  logic                     ReqWrite,
  input  logic [ADDRESS_WIDTH-1:0] PC,
  input  logic [ADDRESS_WIDTH-1:0] ALUOut,
  input  logic [DATA_WIDTH-1:0]    StoreData,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic                     IorD,
  output logic                     MemWrite,
  output logic [DATA_WIDTH-1:0]    WriteData,
  input  logic [DATA_WIDTH-1:0]    MemData,
  output logic [DATA_WIDTH-1:0]    IR,
  output logic [DATA_WIDTH-1:0]    MDR,
  output logic                     Done,
  output logic                     Busy,
  output logic                     Misaligned
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  logic [1:0]               state;
  logic [1:0]               stateNext;
  logic                     reqWriteQ;
  logic                     accept;
  logic                     misSel;
  logic                     capture;
  logic                     cntLoad;
  logic                     cntDec;
  logic                     cntZero;
  logic [ADDRESS_WIDTH-1:0] selAddr;

  assign ReqReady = (state == ST_IDLE) || (state == ST_DONE);
  assign Busy     = (state != ST_IDLE);
  assign Done     = (state == ST_DONE);
  assign accept   = ReqValid && ReqReady;
  assign selAddr  = (ReqIorD == IORD_DATA) ? ALUOut : PC;

  // Fetches flagged as writes follow the write timeline but never strobe memory.
  assign MemWrite = (state == ST_ACCESS) && reqWriteQ && (IorD == IORD_DATA);

  assign capture = ((state == ST_ACCESS) && !reqWriteQ && (WAIT_STATES == 0)) ||
                   ((state == ST_WAIT) && cntZero);

  assign cntLoad = (state == ST_ACCESS) && !reqWriteQ;
  assign cntDec  = (state == ST_WAIT);

  mem_wait_counter #(
    .WIDTH(WAIT_CNT_W)
  ) uWaitCounter (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .load   (cntLoad),
    .loadVal(WAIT_LOAD),
    .dec    (cntDec),
    .zero   (cntZero)
  );

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic misFlag;

  assign misSel = addrMisaligned(selAddr[1:0]);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      misFlag <= 1'b0;
    end else if (accept) begin
      misFlag <= misSel;
    end
  end

  assign Misaligned = (state == ST_DONE) && misFlag;
`else
  assign misSel     = 1'b0;
  assign Misaligned = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (accept) stateNext = misSel ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (reqWriteQ || (WAIT_STATES == 0)) stateNext = ST_DONE;
        else                                 stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        if (cntZero) stateNext = ST_DONE;
      end
      default: begin
        // DONE: a request accepted here starts the next access with no bubble.
        if (accept) stateNext = misSel ? ST_DONE : ST_ACCESS;
        else        stateNext = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      Address   <= '0;
      IorD      <= IORD_INSTR;
      WriteData <= '0;
      reqWriteQ <= 1'b0;
      IR        <= '0;
      MDR       <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        Address   <= selAddr;
        IorD      <= ReqIorD;
        WriteData <= StoreData;
        reqWriteQ <= ReqWrite;
      end
      if (capture) begin
        if (IorD == IORD_INSTR) IR  <= MemData;
        else                    MDR <= MemData;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random
// traffic compared each cycle against a transaction-level timing model.
module tb_mem_access_ctrl;

  localparam int WS = 1;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqIorD = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [31:0] PC = '0;
  logic [31:0] ALUOut = '0;
  logic [31:0] StoreData = '0;
  logic [31:0] Address;
  logic        IorD;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] MemData = '0;
  logic [31:0] IR;
  logic [31:0] MDR;
  logic        Done;
  logic        Busy;
  logic        Misaligned;

  mem_access_ctrl #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .WAIT_STATES  (WS)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqIorD   (ReqIorD),
    .ReqWrite  (ReqWrite),
    .PC        (PC),
    .ALUOut    (ALUOut),
    .StoreData (StoreData),
    .Address   (Address),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .MemData   (MemData),
    .IR        (IR),
    .MDR       (MDR),
    .Done      (Done),
    .Busy      (Busy),
    .Misaligned(Misaligned)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model: one outstanding request described by its
  // accept cycle and completion cycle; outputs follow from cycle arithmetic.
  int          t = 0;
  bit          pending = 0;
  int          accT = 0;
  int          doneT = 0;
  bit          wrM = 0;
  bit          iordM = 0;
  bit          misM = 0;
  bit          isReadM = 0;
  logic [31:0] capM = '0;
  logic [31:0] expAddr = '0;
  logic        expIorD = 1'b0;
  logic [31:0] expWD = '0;
  logic [31:0] expIR = '0;
  logic [31:0] expMDR = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, t, act, exp);
    end
  endtask

  function automatic bit mBusy();
    return pending && (t <= doneT);
  endfunction

  function automatic bit mDone();
    return pending && (t == doneT);
  endfunction

  task automatic checkNow();
    if (mDone() && isReadM) begin
      if (!iordM) expIR  = capM;
      else        expMDR = capM;
    end
    chk("ReqReady", 64'(ReqReady), 64'(!mBusy() || mDone()));
    chk("Busy", 64'(Busy), 64'(mBusy()));
    chk("Done", 64'(Done), 64'(mDone()));
    chk("MemWrite", 64'(MemWrite),
        64'(pending && (t == accT + 1) && wrM && iordM && !misM));
    chk("Misaligned", 64'(Misaligned), 64'(mDone() && misM));
    chk("Address", 64'(Address), 64'(expAddr));
    chk("IorD", 64'(IorD), 64'(expIorD));
    chk("WriteData", 64'(WriteData), 64'(expWD));
    chk("IR", 64'(IR), 64'(expIR));
    chk("MDR", 64'(MDR), 64'(expMDR));
  endtask

  task automatic cycle(input logic v, input logic iord, input logic wr,
                       input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [31:0] md);
    logic [31:0] addr;
    bit          readyNow;
    ReqValid  = v;
    ReqIorD   = iord;
    ReqWrite  = wr;
    PC        = pc;
    ALUOut    = alu;
    StoreData = sd;
    MemData   = md;
    readyNow  = !mBusy() || mDone();
    if (pending && isReadM && (doneT == t + 1)) capM = md;
    if (v && readyNow) begin
      addr    = iord ? alu : pc;
      misM    = ALIGN_EN && (addr[1:0] != 2'b00);
      pending = 1;
      accT    = t;
      wrM     = wr;
      iordM   = iord;
      isReadM = !misM && !wr;
      doneT   = t + (misM ? 1 : (wr ? 2 : 2 + WS));
      expAddr = addr;
      expIorD = iord;
      expWD   = sd;
    end
    @(negedge Clk);
    t++;
    checkNow();
  endtask

  task automatic idle(input logic [31:0] md);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, md);
  endtask

  // Idles until the DUT reports Done; n returns the cycles waited.
  task automatic waitDone(input logic [31:0] md, output int n);
    n = 0;
    while (!Done && n < 20) begin
      idle(md);
      n++;
    end
    if (!Done) chk("done_timeout", 64'(Done), 64'd1);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge Clk);
    chk("rst_ReqReady", 64'(ReqReady), 64'd1);
    chk("rst_Busy", 64'(Busy), 64'd0);
    chk("rst_Address", 64'(Address), 64'd0);
    chk("rst_IR", 64'(IR), 64'd0);
    Reset_n = 1'b1;
    checkNow();

    // Fetch from 0x40 with one wait state.
    cycle(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h8C220004);
    waitDone(32'h8C220004, n);
    chk("fetch_latency", 64'(n + 1), 64'd3);
    chk("fetch_IR", 64'(IR), 64'h8C220004);
    chk("fetch_MDR", 64'(MDR), 64'd0);
    chk("fetch_Address", 64'(Address), 64'h40);
    chk("fetch_IorD", 64'(IorD), 64'd0);

    // Load from 0x104 accepted in the DONE cycle of the fetch.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 32'h104, 32'h0, 32'h12345678);
    chk("b2b_Busy", 64'(Busy), 64'd1);
    chk("b2b_Address", 64'(Address), 64'h104);
    waitDone(32'h12345678, n);
    chk("b2b_latency", 64'(n + 1), 64'd3);
    chk("b2b_MDR", 64'(MDR), 64'h12345678);
    chk("b2b_IR", 64'(IR), 64'h8C220004);

    // Store to 0x100.
    idle(32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0, 32'h100, 32'hDEADBEEF, 32'h0);
    chk("st_MemWrite", 64'(MemWrite), 64'd1);
    chk("st_Address", 64'(Address), 64'h100);
    chk("st_IorD", 64'(IorD), 64'd1);
    chk("st_WriteData", 64'(WriteData), 64'hDEADBEEF);
    idle(32'h0);
    chk("st_MemWrite_off", 64'(MemWrite), 64'd0);
    chk("st_Done", 64'(Done), 64'd1);

    // Fetch with ReqWrite set.
    idle(32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 32'h0000AAAA, 32'h55555555);
    chk("fw_MemWrite", 64'(MemWrite), 64'd0);
    idle(32'h55555555);
    chk("fw_Done", 64'(Done), 64'd1);
    chk("fw_IR", 64'(IR), 64'h8C220004);

    // Store to misaligned 0x102.
    idle(32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h0, 32'h102, 32'hCAFEF00D, 32'h0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    chk("mis_Done", 64'(Done), 64'd1);
    chk("mis_Misaligned", 64'(Misaligned), 64'd1);
    chk("mis_MemWrite", 64'(MemWrite), 64'd0);
`else
    chk("mis_MemWrite", 64'(MemWrite), 64'd1);
    chk("mis_Address", 64'(Address), 64'h102);
    chk("mis_Misaligned", 64'(Misaligned), 64'd0);
`endif
    idle(32'h0);
    idle(32'h0);

    // Reset pulled low during the wait state of a fetch.
    cycle(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 32'h77777777);
    idle(32'h77777777);
    chk("rw_Busy", 64'(Busy), 64'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("rw_MemWrite", 64'(MemWrite), 64'd0);
    chk("rw_Busy0", 64'(Busy), 64'd0);
    chk("rw_ReqReady", 64'(ReqReady), 64'd1);
    chk("rw_Address", 64'(Address), 64'd0);
    chk("rw_IR", 64'(IR), 64'd0);
    chk("rw_MDR", 64'(MDR), 64'd0);
    chk("rw_Done", 64'(Done), 64'd0);
    pending = 0;
    expAddr = '0;
    expIorD = 1'b0;
    expWD   = '0;
    expIR   = '0;
    expMDR  = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    t++;
    checkNow();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      logic [31:0] ralu;
      rpc  = $urandom();
      ralu = $urandom();
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) ralu[1:0] = 2'b00;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), rpc, ralu, $urandom(), $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", t);
    $fatal(1, "watchdog expired");
  end

endmodule
